// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1 data mux toward one
// valid/ready consumer; each grant is capped at MAX_BURST transfers.
module mux_2x1_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             S,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } owner_t;

   state_t           state, state_nxt;
   owner_t           last, last_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   logic             s_nxt, gnt_a_nxt, gnt_b_nxt;
   logic             req_cur, transfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         S         <= 1'b0;
         gnt_a     <= 1'b0;
         gnt_b     <= 1'b0;
         burst_cnt <= '0;
         last      <= LAST_B;
      end else begin
         state     <= state_nxt;
         S         <= s_nxt;
         gnt_a     <= gnt_a_nxt;
         gnt_b     <= gnt_b_nxt;
         burst_cnt <= burst_cnt_nxt;
         last      <= last_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      s_nxt         = S;
      gnt_a_nxt     = gnt_a;
      gnt_b_nxt     = gnt_b;
      burst_cnt_nxt = burst_cnt;
      last_nxt      = last;
      req_cur       = 1'b0;
      out_valid     = 1'b0;
      transfer      = 1'b0;

      case (state)
         IDLE: begin
            // On a tie, whoever was not served last wins.
            if (req_a && (!req_b || last == LAST_B)) begin
               state_nxt     = GRANT_A;
               s_nxt         = 1'b0;
               gnt_a_nxt     = 1'b1;
               burst_cnt_nxt = '0;
            end else if (req_b) begin
               state_nxt     = GRANT_B;
               s_nxt         = 1'b1;
               gnt_b_nxt     = 1'b1;
               burst_cnt_nxt = '0;
            end
         end
         GRANT_A, GRANT_B: begin
            req_cur   = (state == GRANT_A) ? req_a : req_b;
            out_valid = req_cur && !reset;
            transfer  = out_valid && out_ready;
            if (!req_cur || (transfer && burst_cnt == CNT_LAST)) begin
               state_nxt     = IDLE;
               last_nxt      = (state == GRANT_A) ? LAST_A : LAST_B;
               gnt_a_nxt     = 1'b0;
               gnt_b_nxt     = 1'b0;
               burst_cnt_nxt = '0;
            end else if (transfer) begin
               burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign done_a   = transfer && (state == GRANT_A);
   assign done_b   = transfer && (state == GRANT_B);
   assign out_data = S ? data_b : data_a;

endmodule

// File: doc/mux_2x1_arbiter.md
Name: mux_2x1_arbiter

Overview:
Round-robin arbiter that shares one 2:1 multiplexer datapath between two requesters (A, B) feeding a single downstream consumer with a valid/ready handshake. It drives the mux select S, issues grants, and limits each grant to a bounded burst so neither requester starves. It sits between two producer blocks and the shared output channel, replacing the tester-driven select with a sequenced controller.

Parameters:
WIDTH, 8, data width of each requester input and of out_data
MAX_BURST, 4, maximum transfers per grant before the arbiter re-arbitrates (≥1)

Ports:
clk  input  1  single system clock, rising-edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A has data available (level, held until served)
data_a  input  WIDTH  requester A data
req_b  input  1  requester B has data available
data_b  input  WIDTH  requester B data
out_ready  input  1  downstream accepts out_data this cycle
out_valid  output  1  out_data valid this cycle
out_data  output  WIDTH  muxed data: data_a when S=0, data_b when S=1
S  output  1  registered mux select (0=A, 1=B)
gnt_a  output  1  registered grant to A
gnt_b  output  1  registered grant to B
done_a  output  1  one-cycle pulse: A word transferred this cycle
done_b  output  1  one-cycle pulse: B word transferred this cycle

Behaviour:
- One clock; reset is synchronous and active-high: sampled only on rising clk.
- Reset values: state=IDLE, S=0, gnt_a=0, gnt_b=0, burst_cnt=0, last=B (A wins first tie). Combinational outputs evaluate to out_valid=0, done_a=0, done_b=0, out_data=data_a.
- Reset asserted mid-burst: next edge forces reset values; no transfer completes in a cycle where reset is high (out_valid forced 0 while reset=1).
- States: IDLE, GRANT_A, GRANT_B.
- IDLE: gnt_a=gnt_b=0, S holds its previous value.
  - req_a&req_b: grant the one ≠ last (round robin).
  - only req_a → GRANT_A; only req_b → GRANT_B; none → stay.
  - On entry to GRANT_X: S set (A→0, B→1), gnt_X=1, burst_cnt=0, all on the same edge.
- GRANT_X:
  - out_valid = req_X (combinational); out_data = mux(data_a, data_b, S).
  - transfer = out_valid & out_ready; done_X = transfer.
  - transfer: burst_cnt += 1.
  - Exit to IDLE when (transfer && burst_cnt==MAX_BURST-1) or !req_X; on exit last=X, gnt_X=0, burst_cnt=0.
  - out_ready low: hold state, count and data; no timeout.
- Latency: request in IDLE at edge n → grant/S visible after edge n → first possible transfer in cycle n+1. After every grant exit, exactly one IDLE cycle (arbitration bubble) before the next grant.
- Max throughput: MAX_BURST words per MAX_BURST+1 cycles.
- Never gnt_a&gnt_b; out_valid never 1 in IDLE; S never changes while a grant is held.
- burst_cnt width = clog2(MAX_BURST)+1; never exceeds MAX_BURST-1.
- MAX_BURST=1: every transfer ends the grant.
- Requester dropping req mid-burst: exit on that cycle's edge, no transfer counted, last updated to it.

Test Plan:
- Reset: hold reset 2 cycles with req_a=req_b=1 → S=0, gnt_a=gnt_b=0, out_valid=0; release → gnt_a=1 next edge, then gnt_b after A's burst.
- Single requester: req_a=1, data_a=8'h5A, out_ready=1, MAX_BURST=4 → 4 done_a pulses, out_data=8'h5A, 1 IDLE cycle, 4 more (cycles 1-4, 6-9).
- Contention fairness: req_a=req_b=1 continuously, out_ready=1 → grants alternate A,B,A,B; each 4 transfers; S toggles only in IDLE; 20 transfers in 25 cycles.
- Backpressure: GRANT_B, out_ready=0 for 3 cycles → out_valid=1, S=1, burst_cnt frozen; data_b=8'hC3 transferred when out_ready returns.
- Early drop: GRANT_A, req_a falls after 2 transfers with req_b=1 → IDLE next edge, then gnt_b=1, S=1; last=A.
- Mid-burst reset: reset=1 during GRANT_B after 1 transfer → next edge IDLE, S=0, counters 0, no done_b while reset high.
